// File: rtl/motor_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motor_cmd_parser: decodes SYNC,A,B,CHK frames into signed speeds for the    |
// | PWM driver. Optional macro CMD_ERR_COUNT_EN adds err_count output.          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module motor_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter logic [7:0] CHK_SEED     = 8'h5A,
  parameter int         BYTE_TIMEOUT = 16000
) (
  input  logic       clk_16mhz,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] speedA,
  output logic [7:0] speedB,
  output logic       aliveStrobe,
  output logic       frame_ok,
  output logic       frame_err
`ifdef CMD_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int            CW        = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [CW-1:0] C_TIMEOUT = CW'(BYTE_TIMEOUT);

  typedef enum logic [1:0] {IDLE, GOT_SYNC, GOT_A, GOT_B} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_a;
  logic [7:0]    r_b;

  logic w_chk_ok;
  logic w_expire;
  logic w_bad_chk;
  logic w_err_now;

  // A byte arriving on the expiry cycle takes priority, hence the !rx_valid term.
  assign w_chk_ok  = (rx_data == (r_a ^ r_b ^ CHK_SEED));
  assign w_expire  = (r_state != IDLE) && !rx_valid && (r_cnt <= CW'(1));
  assign w_bad_chk = rx_valid && (r_state == GOT_B) && !w_chk_ok;
  assign w_err_now = w_bad_chk || w_expire;

  // -128 would wrap to zero ticks in the driver's 7-bit magnitude path.
  function automatic logic [7:0] clamp(input logic [7:0] v);
    return (v == 8'h80) ? 8'h81 : v;
  endfunction

  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      speedA      <= '0;
      speedB      <= '0;
      aliveStrobe <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= w_err_now;
      if (rx_valid) begin
        case (r_state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              r_state <= GOT_SYNC;
              r_cnt   <= C_TIMEOUT;
            end
          end
          GOT_SYNC: begin
            r_a     <= rx_data;
            r_state <= GOT_A;
            r_cnt   <= C_TIMEOUT;
          end
          GOT_A: begin
            r_b     <= rx_data;
            r_state <= GOT_B;
            r_cnt   <= C_TIMEOUT;
          end
          GOT_B: begin
            r_state <= IDLE;
            r_cnt   <= '0;
            if (w_chk_ok) begin
              speedA      <= clamp(r_a);
              speedB      <= clamp(r_b);
              aliveStrobe <= ~aliveStrobe;
              frame_ok    <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (w_expire) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

`ifdef CMD_ERR_COUNT_EN
  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      err_count <= '0;
    end else if (w_err_now && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire
